data_mem_master: RTL and testbench
==================================

# data_mem_master

Initiator side of the data-memory port: accepts single load/store requests from the CPU datapath through a valid/ready handshake and drives the synchronous data memory. The memory writes on `we=1` and registers read data on `we=0` at each rising clock edge. The block converts byte addresses to word indices and rejects misaligned or out-of-range accesses without touching memory. It returns one single-cycle response per accepted request, carrying read data or an error flag.

## Interface
- `SIZE`, 32, word and address width in bits
- `MEM_SIZE`, 1024, number of words in the attached memory; the legal word index range is 0..MEM_SIZE-1
- `clk` input 1: single clock; all state changes on the rising edge
- `rst` input 1: reset, synchronous and active-high
- `req_valid` input 1: request present
- `req_ready` output 1: block can accept a request; high only in IDLE
- `req_we` input 1: 1 = store, 0 = load
- `req_addr` input SIZE: byte address
- `req_wdata` input SIZE: store data
- `rsp_valid` output 1: one-cycle response pulse
- `rsp_err` output 1: qualifies `rsp_valid`; 1 = request rejected
- `rsp_rdata` output SIZE: load data, qualified by `rsp_valid & ~rsp_err & load`
- `mem_addr` output SIZE: word index to memory
- `mem_data_in` output SIZE: write data to memory
- `mem_we` output 1: write enable to memory
- `mem_data_out` input SIZE: registered read data from memory

## Operation
- FSM states and transitions:
  - IDLE: to CHECK-less dispatch on handshake
  - ACCESS: the memory operation is in flight
  - CAPTURE: loads only
  - RESP
- Handshake: a request is accepted at a rising edge where `req_valid & req_ready`. Requests are never queued. `req_valid` while busy is ignored and has no side effects.
- Acceptance checks, evaluated on `req_addr` at the accepting edge:
  - Misaligned: `req_addr[1:0] != 0`
  - Out of range: `req_addr[SIZE-1:2] >= MEM_SIZE`
- Rejected request, at the accepting edge:
  - State goes to RESP.
  - `rsp_valid=1`, `rsp_err=1`, `rsp_rdata=0`.
  - `mem_we` stays 0; `mem_addr` and `mem_data_in` are unchanged.
- Legal request, at the accepting edge:
  - `mem_addr <= {2'b00, req_addr[SIZE-1:2]}`
  - `mem_data_in <= req_wdata` for stores only; otherwise it holds.
  - `mem_we <= req_we`
  - State goes to ACCESS.
- ACCESS, store:
  - At the next edge the memory commits the write.
  - The block sets `mem_we <= 0`, `rsp_valid <= 1`, `rsp_err <= 0`, `rsp_rdata <= 0`.
  - State goes to RESP.
- ACCESS, load:
  - `mem_we` remains 0 and the memory registers the word.
  - State goes to CAPTURE.
- CAPTURE:
  - `rsp_rdata <= mem_data_out`, `rsp_valid <= 1`, `rsp_err <= 0`.
  - State goes to RESP.
- RESP:
  - `rsp_valid <= 0`; `rsp_err` and `rsp_rdata` hold their values.
  - State goes to IDLE.
- `mem_we` is 1 for exactly one cycle per legal store and never 1 otherwise.
- `mem_addr` holds its last value between accesses. Memory reads while idle are harmless and ignored.

## Timing
- Reset values: state IDLE, `req_ready=1` (combinational, state==IDLE), `rsp_valid=0`, `rsp_err=0`, `rsp_rdata=0`, `mem_addr=0`, `mem_data_in=0`, `mem_we=0`.
- Label the accepting edge E0. All counts below are edges after E0.
- Store: `mem_we` is high between E0 and E1, and the memory writes at E1. `rsp_valid` is high between E1 and E2. `req_ready` is high again after E2. Throughput is 1 store per 3 cycles.
- Load: the memory latches data at E1 and the block captures it at E2. `rsp_valid` and valid `rsp_rdata` are present between E2 and E3. `req_ready` is high again after E3. Throughput is 1 load per 4 cycles.
- Error: `rsp_valid`/`rsp_err` are high between E0 and E1. `req_ready` is high again after E1.
- Reset asserted at E1 of a store:
  - The memory still samples `mem_we=1` and the write commits.
  - No response is issued and all outputs take their reset values.
- Reset asserted at any other edge mid-operation:
  - The operation is abandoned and no response is issued.
  - Memory contents are unaffected.
- `rst` has priority over a simultaneous `req_valid` and over every state transition.

## Test plan
- Reset, then load at byte 0x0 -> `rsp_valid` 2 cycles after accept, `rsp_err=0`, `rsp_rdata=0x00000000`.
- Store 0xDEADBEEF at 0x40, then load 0x40:
  - Store: `mem_addr=0x10`, `mem_we` high for 1 cycle, response after 1 cycle.
  - Load: returns 0xDEADBEEF.
- Store at 0x6 (misaligned) -> `rsp_err=1` in the cycle after accept, `mem_we` never asserted. A load of 0x4 afterwards is unchanged.
- Load at 0x1000 (word 1024 = MEM_SIZE) -> `rsp_err=1`. Load at 0xFFC (word 1023) -> `rsp_err=0`.
- Hold `req_valid=1` continuously with alternating addresses -> exactly one acceptance per IDLE visit, requests during busy ignored, exactly one `rsp_valid` pulse each.
- Reset during CAPTURE of a load -> no `rsp_valid`, outputs at reset values, next request served normally.

Source files
------------

// File: rtl/data_mem_master.sv
// rtl/data_mem_master.sv - load/store initiator for the synchronous data memory
// Screens each request for alignment and range, then drives one memory access and one response pulse.
module data_mem_master #(
  parameter int SIZE     = 32,
  parameter int MEM_SIZE = 1024
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [SIZE-1:0] req_addr,
  input  logic [SIZE-1:0] req_wdata,
  output logic            rsp_valid,
  output logic            rsp_err,
  output logic [SIZE-1:0] rsp_rdata,
  output logic [SIZE-1:0] mem_addr,
  output logic [SIZE-1:0] mem_data_in,
  output logic            mem_we,
  input  logic [SIZE-1:0] mem_data_out
);

  typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, RESP} state_t;

  localparam logic [SIZE-1:0] MEM_WORDS = SIZE'(MEM_SIZE);

  state_t          state, state_next;
  logic            accept;
  logic            bad_req;
  logic [SIZE-1:0] word_idx;

  assign req_ready = (state == IDLE);
  assign accept    = req_valid & req_ready;
  assign word_idx  = {2'b00, req_addr[SIZE-1:2]};
  assign bad_req   = (req_addr[1:0] != 2'b00) || (word_idx >= MEM_WORDS);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // In ACCESS, mem_we still tells store from load, so no separate op flag is kept.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = bad_req ? RESP : ACCESS;
      ACCESS:  state_next = mem_we ? RESP : CAPTURE;
      CAPTURE: state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid   <= 1'b0;
      rsp_err     <= 1'b0;
      rsp_rdata   <= '0;
      mem_addr    <= '0;
      mem_data_in <= '0;
      mem_we      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (bad_req) begin
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
            end else begin
              mem_addr <= word_idx;
              mem_we   <= req_we;
              if (req_we) mem_data_in <= req_wdata;
            end
          end
        end
        ACCESS: begin
          if (mem_we) begin
            mem_we    <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
          end
        end
        CAPTURE: begin
          rsp_rdata <= mem_data_out;
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b0;
        end
        RESP:    rsp_valid <= 1'b0;
        default: rsp_valid <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_master.sv
// tb/tb_data_mem_master.sv - directed bench for data_mem_master with a transaction-level reference model
// Holds the attached synchronous memory, a response-timing model and literal checks.
module tb_data_mem_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_err;
  logic [31:0] rsp_rdata;
  logic [31:0] mem_addr;
  logic [31:0] mem_data_in;
  logic        mem_we;
  logic [31:0] mem_data_out = '0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  data_mem_master #(.SIZE(32), .MEM_SIZE(1024)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_we(mem_we),
    .mem_data_out(mem_data_out)
  );

  // Attached memory: writes on mem_we, registers read data every edge.
  logic [31:0] mem [0:1023];
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[9:0]] <= mem_data_in;
    mem_data_out <= mem[mem_addr[9:0]];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: each accepted request fixes its response edge and the edge after which
  // the block is free again; stores take effect in the model memory when accepted.
  logic [31:0] model_mem [0:1023];
  int          n = 0;
  int          free_edge = 0;
  int          rsp_edge = -1;
  bit          armed = 1'b0;
  logic        pend_err;
  logic [31:0] pend_rdata;
  logic        exp_valid = 1'b0, exp_err = 1'b0, exp_we = 1'b0;
  logic [31:0] exp_rdata = '0, exp_addr = '0, exp_wdata = '0;

  always @(posedge clk) begin
    n = n + 1;
    exp_we = 1'b0;
    if (rst) begin
      armed = 1'b1;
      free_edge = n;
      rsp_edge = -1;
      exp_valid = 1'b0; exp_err = 1'b0; exp_rdata = '0;
      exp_addr = '0; exp_wdata = '0;
    end else begin
      exp_valid = 1'b0;
      if (n == rsp_edge) begin
        exp_valid = 1'b1; exp_err = pend_err; exp_rdata = pend_rdata;
        rsp_edge = -1;
      end
      if (req_valid && (n - 1 >= free_edge)) begin
        if (req_addr[1:0] != 2'b00 || (req_addr >> 2) >= 32'd1024) begin
          exp_valid = 1'b1; exp_err = 1'b1; exp_rdata = '0;
          free_edge = n + 1;
        end else if (req_we) begin
          exp_we = 1'b1;
          exp_addr = req_addr >> 2;
          exp_wdata = req_wdata;
          model_mem[req_addr[11:2]] = req_wdata;
          pend_err = 1'b0; pend_rdata = '0;
          rsp_edge = n + 1; free_edge = n + 2;
        end else begin
          exp_addr = req_addr >> 2;
          pend_err = 1'b0; pend_rdata = model_mem[req_addr[11:2]];
          rsp_edge = n + 2; free_edge = n + 3;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      check("req_ready",   32'(req_ready), 32'(n >= free_edge));
      check("rsp_valid",   32'(rsp_valid), 32'(exp_valid));
      check("rsp_err",     32'(rsp_err),   32'(exp_err));
      check("rsp_rdata",   rsp_rdata,      exp_rdata);
      check("mem_we",      32'(mem_we),    32'(exp_we));
      check("mem_addr",    mem_addr,       exp_addr);
      check("mem_data_in", mem_data_in,    exp_wdata);
    end
  end

  // Issues one request and returns the number of edges after the accepting edge until rsp_valid.
  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       output int lat);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = -1;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      if (rsp_valid) begin
        lat = i;
        break;
      end
    end
  endtask

  int lat;
  int pulses;

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem[i] = '0;
      model_mem[i] = '0;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;

    issue(1'b0, 32'h0, 32'h0, lat);
    check("load0_lat", lat, 2);
    check("load0_err", 32'(rsp_err), 0);
    check("load0_data", rsp_rdata, 32'h0);

    issue(1'b1, 32'h40, 32'hDEADBEEF, lat);
    check("store40_lat", lat, 1);
    check("store40_err", 32'(rsp_err), 0);
    check("store40_mem_addr", mem_addr, 32'h10);

    issue(1'b0, 32'h40, 32'h0, lat);
    check("load40_lat", lat, 2);
    check("load40_data", rsp_rdata, 32'hDEADBEEF);

    issue(1'b1, 32'h6, 32'hFFFFFFFF, lat);
    check("misalign_lat", lat, 0);
    check("misalign_err", 32'(rsp_err), 1);
    issue(1'b0, 32'h4, 32'h0, lat);
    check("load4_err", 32'(rsp_err), 0);
    check("load4_data", rsp_rdata, 32'h0);

    issue(1'b0, 32'h1000, 32'h0, lat);
    check("oor_lat", lat, 0);
    check("oor_err", 32'(rsp_err), 1);
    issue(1'b0, 32'hFFC, 32'h0, lat);
    check("last_word_lat", lat, 2);
    check("last_word_err", 32'(rsp_err), 0);

    // req_valid held for 16 edges: loads are accepted on edges 1, 5, 9 and 13 only.
    pulses = 0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (rsp_valid) pulses++;
      req_valid = 1'b1; req_we = 1'b0;
      req_addr = k[0] ? 32'h44 : 32'h40;
    end
    @(negedge clk);
    if (rsp_valid) pulses++;
    req_valid = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (rsp_valid) pulses++;
    end
    check("hold_pulses", pulses, 4);

    issue(1'b0, 32'h40, 32'h0, lat);
    check("pre_rst_data", rsp_rdata, 32'hDEADBEEF);

    // Reset lands on the edge where the load would be captured.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h40;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("cap_rst_valid", 32'(rsp_valid), 0);
    check("cap_rst_rdata", rsp_rdata, 32'h0);
    check("cap_rst_addr", mem_addr, 32'h0);
    rst = 1'b0;
    issue(1'b0, 32'h40, 32'h0, lat);
    check("post_rst_lat", lat, 2);
    check("post_rst_data", rsp_rdata, 32'hDEADBEEF);

    // Reset lands on the store's write edge; the write still commits.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h100; req_wdata = 32'h12345678;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("st_rst_valid", 32'(rsp_valid), 0);
    check("st_rst_we", 32'(mem_we), 0);
    rst = 1'b0;
    issue(1'b0, 32'h100, 32'h0, lat);
    check("st_rst_data", rsp_rdata, 32'h12345678);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
